// File: rtl/score_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : score_sequencer
// Description : Multi-channel score player. Fetches 16-bit command words from
//               a synchronous score ROM (one cycle read latency), interprets
//               tempo/volume/voice/note/rest/end commands and drives
//               per-channel note, volume, voice and gate registers.
// Revision    : 1.0 - initial release
// ============================================================================
module score_sequencer #(
  parameter int               ADDR_W  = 13,
  parameter int               NCH     = 4,
  parameter int               DIV_W   = 16,
  parameter logic [DIV_W-1:0] DEF_DIV = DIV_W'(50000)
) (
  input  logic              clk,
  input  logic              asyncrst,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [NCH-1:0]    gate,
  output logic [NCH*8-1:0]  note,
  output logic [NCH*8-1:0]  vol,
  output logic [NCH*8-1:0]  voice
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ADDR     = 3'd1;
  localparam logic [2:0] S_DATA     = 3'd2;
  localparam logic [2:0] S_ARG_ADDR = 3'd3;
  localparam logic [2:0] S_ARG_DATA = 3'd4;
  localparam logic [2:0] S_WAIT     = 3'd5;
  localparam logic [2:0] S_END      = 3'd6;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_TEMPO = 4'h1;
  localparam logic [3:0] OP_VOL   = 4'h2;
  localparam logic [3:0] OP_VOICE = 4'h3;
  localparam logic [3:0] OP_NOTEW = 4'h4;
  localparam logic [3:0] OP_NOTE  = 4'h5;
  localparam logic [3:0] OP_REST  = 4'h6;
  localparam logic [3:0] OP_END   = 4'hF;

  // channel field compared in 5 bits so NCH=16 needs no special case
  localparam logic [4:0] NCH_LIM = 5'(NCH);

  logic [2:0]       state;
  logic [3:0]       op_q;      // opcode of a two-word command awaiting its argument
  logic [DIV_W-1:0] tick_div;
  logic [DIV_W-1:0] presc;
  logic [15:0]      remain;    // ticks still to wait

  logic [3:0]       op;
  logic [3:0]       ch;
  logic [7:0]       arg;
  logic             ch_ok;
  logic             in_data;
  logic             op_writes;
  logic             op_bad;
  logic             tick;
  logic             wait_exit;
  logic             gate_clr;
  logic [DIV_W-1:0] tempo_val;

  // Command word decode and shared gate/tick conditions
  always_comb begin
    op        = rom_data[15:12];
    ch        = rom_data[11:8];
    arg       = rom_data[7:0];
    ch_ok     = ({1'b0, ch} < NCH_LIM);
    in_data   = (state == S_DATA) && !stop;
    op_writes = (op == OP_VOL) || (op == OP_VOICE) || (op == OP_NOTEW) || (op == OP_NOTE);
    op_bad    = (op >= 4'h7) && (op <= 4'hE);
    tick      = (presc == tick_div - DIV_W'(1));
    wait_exit = (state == S_WAIT) && tick && (remain == 16'd1);
    gate_clr  = stop || ((state == S_IDLE) && start) || (state == S_END) ||
                wait_exit || (in_data && (op == OP_REST));
    tempo_val = DIV_W'(rom_data);
  end

  // Sequencer FSM: fetch, argument fetch, tick wait and end handling
  always_ff @(posedge clk or posedge asyncrst) begin
    if (asyncrst) begin
      state    <= S_IDLE;
      rom_addr <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      tick_div <= DEF_DIV;
      presc    <= '0;
      remain   <= '0;
      op_q     <= OP_NOP;
    end else begin
      done <= 1'b0;
      if (stop) begin
        state <= S_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              rom_addr <= '0;
              busy     <= 1'b1;
              err      <= 1'b0;
              state    <= S_ADDR;
            end
          end
          S_ADDR: state <= S_DATA;
          S_DATA: begin
            op_q <= op;
            if (op_bad || (op_writes && !ch_ok))
              err <= 1'b1;
            if (op == OP_END) begin
              state <= S_END;
            end else if ((op == OP_TEMPO) || (op == OP_NOTEW) || (op == OP_REST)) begin
              rom_addr <= rom_addr + ADDR_W'(1);
              state    <= S_ARG_ADDR;
            end else begin
              rom_addr <= rom_addr + ADDR_W'(1);
              state    <= S_ADDR;
            end
          end
          S_ARG_ADDR: state <= S_ARG_DATA;
          S_ARG_DATA: begin
            if (op_q == OP_TEMPO) begin
              tick_div <= (tempo_val == '0) ? DIV_W'(1) : tempo_val;
              rom_addr <= rom_addr + ADDR_W'(1);
              state    <= S_ADDR;
            end else if (rom_data == 16'd0) begin
              // zero duration: no wait, gates left as they are
              rom_addr <= rom_addr + ADDR_W'(1);
              state    <= S_ADDR;
            end else begin
              // the next address is issued only when the wait ends
              presc  <= '0;
              remain <= rom_data;
              state  <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (tick) begin
              presc <= '0;
              if (remain == 16'd1) begin
                rom_addr <= rom_addr + ADDR_W'(1);
                state    <= S_ADDR;
              end else begin
                remain <= remain - 16'd1;
              end
            end else begin
              presc <= presc + DIV_W'(1);
            end
          end
          S_END: begin
            if (loop_en) begin
              rom_addr <= '0;
              state    <= S_ADDR;
            end else begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  generate
    for (genvar c = 0; c < NCH; c++) begin : g_ch
      logic       sel;
      logic [7:0] note_r;
      logic [7:0] vol_r;
      logic [7:0] voice_r;
      logic       gate_r;

      assign sel                = in_data && (ch == 4'(c));
      assign note[8*c +: 8]     = note_r;
      assign vol[8*c +: 8]      = vol_r;
      assign voice[8*c +: 8]    = voice_r;
      assign gate[c]            = gate_r;

      // Per-channel registers; clearing all gates wins over a new note
      always_ff @(posedge clk or posedge asyncrst) begin
        if (asyncrst) begin
          note_r  <= 8'd0;
          vol_r   <= 8'd0;
          voice_r <= 8'd0;
          gate_r  <= 1'b0;
        end else begin
          if (sel && (op == OP_VOL))
            vol_r <= arg;
          if (sel && (op == OP_VOICE))
            voice_r <= arg;
          if (sel && ((op == OP_NOTEW) || (op == OP_NOTE)))
            note_r <= arg;
          if (gate_clr)
            gate_r <= 1'b0;
          else if (sel && ((op == OP_NOTEW) || (op == OP_NOTE)))
            gate_r <= 1'b1;
        end
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_score_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_score_sequencer
// Description : Self-checking bench for score_sequencer: directed scores plus
//               randomized scores against an event-timeline reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_score_sequencer;

  localparam int ADDR_W = 13;
  localparam int NCH    = 4;
  localparam int DIV_W  = 16;
  localparam int ROM_N  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              asyncrst;
  logic              start;
  logic              stop;
  logic              loop_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [15:0]       rom_data;
  logic              busy;
  logic              done;
  logic              err;
  logic [NCH-1:0]    gate;
  logic [NCH*8-1:0]  note;
  logic [NCH*8-1:0]  vol;
  logic [NCH*8-1:0]  voice;

  score_sequencer #(
    .ADDR_W (ADDR_W),
    .NCH    (NCH),
    .DIV_W  (DIV_W),
    .DEF_DIV(16'd4)
  ) dut (
    .clk     (clk),
    .asyncrst(asyncrst),
    .start   (start),
    .stop    (stop),
    .loop_en (loop_en),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .gate    (gate),
    .note    (note),
    .vol     (vol),
    .voice   (voice)
  );

  always #5 clk = ~clk;

  // synchronous score ROM, one cycle of read latency
  logic [15:0] rom [ROM_N];
  initial rom_data = 16'd0;
  always @(posedge clk) rom_data <= rom[rom_addr];

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- score loading ----------------
  int wp;
  task automatic new_score();
    for (int i = 0; i < 64; i++) rom[i] = 16'hFFFF;
    wp = 0;
  endtask
  task automatic put(input logic [15:0] w);
    rom[wp] = w;
    wp++;
  endtask

  // ---------------- reference model ----------------
  // Time t counts clock edges after the edge that accepts start. Every word
  // costs two edges, a wait costs duration*div edges, END costs one more.
  int m_note [NCH];
  int m_vol  [NCH];
  int m_voice[NCH];
  int m_ghi  [NCH];
  int m_on   [NCH];
  int m_div;
  int m_err;
  int m_cyc;

  task automatic m_reset();
    for (int c = 0; c < NCH; c++) begin
      m_note[c] = 0; m_vol[c] = 0; m_voice[c] = 0;
    end
    m_div = 4;
    m_err = 0;
  endtask

  task automatic m_clear(input int tc);
    for (int c = 0; c < NCH; c++)
      if (m_on[c] >= 0) begin
        m_ghi[c] += tc - m_on[c];
        m_on[c] = -1;
      end
  endtask

  task automatic model_run();
    int t, a, op, ch, arg, w2;
    bit fin;
    m_err = 0; t = 0; a = 0; fin = 0; m_cyc = -1;
    for (int c = 0; c < NCH; c++) begin m_on[c] = -1; m_ghi[c] = 0; end
    for (int n = 0; n < 4000 && !fin; n++) begin
      op  = int'(rom[a][15:12]);
      ch  = int'(rom[a][11:8]);
      arg = int'(rom[a][7:0]);
      w2  = int'(rom[(a + 1) % ROM_N]);
      if (op == 15) begin
        m_clear(t + 3);
        m_cyc = t + 3;
        fin = 1;
      end else if (op == 1 || op == 4 || op == 6) begin
        if (op == 1) m_div = (w2 == 0) ? 1 : w2;
        if (op == 6) m_clear(t + 2);
        if (op == 4) begin
          if (ch < NCH) begin
            m_note[ch] = arg;
            if (m_on[ch] < 0) m_on[ch] = t + 2;
          end else m_err = 1;
        end
        t += 4;
        a = (a + 2) % ROM_N;
        if (op != 1 && w2 != 0) begin
          t += w2 * m_div;
          m_clear(t);
        end
      end else begin
        if (op >= 7) m_err = 1;
        else if (op >= 2) begin
          if (ch >= NCH) m_err = 1;
          else if (op == 2) m_vol[ch] = arg;
          else if (op == 3) m_voice[ch] = arg;
          else begin
            m_note[ch] = arg;
            if (m_on[ch] < 0) m_on[ch] = t + 2;
          end
        end
        t += 2;
        a = (a + 1) % ROM_N;
      end
    end
  endtask

  // ---------------- run and observe ----------------
  int             r_cyc;
  int             r_ghi[NCH];
  logic           r_err0;
  logic [NCH-1:0] gq[$];

  // entered just after an edge; returns at the sample where done is seen
  task automatic run_score(input int budget);
    bit seen;
    seen = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    r_err0 = err;
    r_cyc = 0;
    for (int c = 0; c < NCH; c++) r_ghi[c] = 0;
    gq.delete();
    while (r_cyc < budget && !seen) begin
      @(posedge clk); #1;
      r_cyc++;
      gq.push_back(gate);
      for (int c = 0; c < NCH; c++) if (gate[c]) r_ghi[c]++;
      if (done) seen = 1;
    end
    check("done_seen", 32'(seen), 1);
  endtask

  task automatic check_run(input string tag);
    check({tag, "_cycles"}, r_cyc, m_cyc);
    check({tag, "_err"}, 32'(err), m_err);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_gate"}, 32'(gate), 0);
    for (int c = 0; c < NCH; c++) begin
      check($sformatf("%s_note%0d", tag, c),  32'(note[8*c +: 8]),  m_note[c]);
      check($sformatf("%s_vol%0d", tag, c),   32'(vol[8*c +: 8]),   m_vol[c]);
      check($sformatf("%s_voice%0d", tag, c), 32'(voice[8*c +: 8]), m_voice[c]);
      check($sformatf("%s_gatecyc%0d", tag, c), r_ghi[c], m_ghi[c]);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, last, n, kind;
    bit saw_wrap, saw_done, busy_low;
    logic [ADDR_W-1:0] prev;
    logic [3:0] ch4, o4;
    logic [7:0] ar8;

    asyncrst = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
    for (int i = 0; i < ROM_N; i++) rom[i] = 16'hFFFF;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_gate", 32'(gate), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_addr", 32'(rom_addr), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_note", 32'(note), 0);
    check("rst_vol", 32'(vol), 0);
    check("rst_voice", 32'(voice), 0);
    asyncrst = 1'b0;
    @(posedge clk); #1;

    // basic score
    new_score();
    put(16'h1000); put(16'h0003); put(16'h2040); put(16'h4012); put(16'h0002); put(16'hF000);
    model_run();
    run_score(500);
    check_run("basic");
    check("basic_vol0", 32'(vol[7:0]), 32'h40);
    check("basic_note0", 32'(note[7:0]), 32'h12);
    check("basic_cycles_abs", r_cyc, 19);        // 6 words*2 + END + 2 ticks*3
    check("basic_gate0_cyc", r_ghi[0], 8);       // arg fetch (2) + 6 wait cycles
    check("basic_done", 32'(done), 1);
    @(posedge clk); #1;
    check("basic_done_pulse", 32'(done), 0);

    // chord
    new_score();
    put(16'h5130); put(16'h5234); put(16'h4037); put(16'h0001); put(16'hF000);
    model_run();
    run_score(500);
    check_run("chord");
    k = 0; last = -1;
    foreach (gq[i]) if (gq[i] == 4'b0111) begin k++; last = i; end
    check("chord_all_on_cycles", k, 5);
    if (last >= 0 && last + 1 < gq.size())
      check("chord_all_clear", 32'(gq[last + 1]), 0);
    else
      check("chord_all_clear_idx", last, 0);

    // loop, then stop
    new_score();
    put(16'h5220); put(16'h0000); put(16'hF000);
    model_run();
    loop_en = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    saw_wrap = 0; saw_done = 0; busy_low = 0; prev = rom_addr;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (prev == 2 && rom_addr == 0) saw_wrap = 1;
      if (done) saw_done = 1;
      if (!busy) busy_low = 1;
      prev = rom_addr;
    end
    check("loop_wrap", 32'(saw_wrap), 1);
    check("loop_no_done", 32'(saw_done), 0);
    check("loop_busy_held", 32'(busy_low), 0);
    k = 0;
    while (!gate[2] && k < 20) begin @(posedge clk); #1; k++; end
    check("loop_gate_on", 32'(gate[2]), 1);
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    check("stop_gate", 32'(gate), 0);
    check("stop_busy", 32'(busy), 0);
    check("stop_done", 32'(done), 0);
    check("stop_note_held", 32'(note[23:16]), m_note[2]);
    loop_en = 1'b0;
    @(posedge clk); #1;

    // errors
    new_score();
    put(16'h4512); put(16'h0001); put(16'h7000); put(16'hF000);
    model_run();
    run_score(500);
    check_run("errs");
    check("errs_cycles_abs", r_cyc, 12);         // 4 words*2 + END + 1 tick*3
    check("errs_sticky", 32'(err), 1);
    @(posedge clk); #1;

    // duration 0: gate held, no wait; also start clears err
    new_score();
    put(16'h4125); put(16'h0000); put(16'hF000);
    model_run();
    run_score(500);
    check("err_cleared_by_start", 32'(r_err0), 0);
    check_run("dur0");
    check("dur0_cycles_abs", r_cyc, 7);
    check("dur0_gate1_cyc", r_ghi[1], 5);
    @(posedge clk); #1;

    // tempo 0 stored as 1
    new_score();
    put(16'h1000); put(16'h0000); put(16'h4001); put(16'h0003); put(16'hF000);
    model_run();
    run_score(500);
    check_run("tempo0");
    check("tempo0_cycles_abs", r_cyc, 14);
    @(posedge clk); #1;

    // unprogrammed 0xFFFF word terminates
    new_score();
    put(16'h2033);
    model_run();
    run_score(500);
    check_run("fill");
    check("fill_cycles_abs", r_cyc, 5);
    @(posedge clk); #1;

    // reset in the middle of a wait
    new_score();
    put(16'h4001); put(16'h0005); put(16'hF000);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (!gate[0] && k < 20) begin @(posedge clk); #1; k++; end
    repeat (3) @(posedge clk);
    #3;
    asyncrst = 1'b1;
    #1;
    check("midrst_gate", 32'(gate), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_addr", 32'(rom_addr), 0);
    check("midrst_note", 32'(note), 0);
    asyncrst = 1'b0;
    m_reset();
    @(posedge clk); #1;
    new_score();
    put(16'h4001); put(16'h0002); put(16'hF000);
    model_run();
    run_score(500);
    check_run("postrst");
    check("postrst_cycles_abs", r_cyc, 15);      // 3 words*2 + END + 2 ticks*4
    @(posedge clk); #1;

    // randomized scores
    for (int it = 0; it < 12; it++) begin
      new_score();
      n = $urandom_range(3, 8);
      for (int j = 0; j < n; j++) begin
        kind = $urandom_range(0, 9);
        ch4  = 4'($urandom_range(0, 5));
        ar8  = 8'($urandom_range(0, 255));
        case (kind)
          1:       begin put({4'h1, ch4, ar8}); put(16'($urandom_range(0, 3))); end
          2:       put({4'h2, ch4, ar8});
          3:       put({4'h3, ch4, ar8});
          4, 5:    begin put({4'h4, ch4, ar8}); put(16'($urandom_range(0, 3))); end
          6:       put({4'h5, ch4, ar8});
          7:       begin put({4'h6, ch4, ar8}); put(16'($urandom_range(0, 3))); end
          8:       begin o4 = 4'($urandom_range(7, 14)); put({o4, ch4, ar8}); end
          default: put({4'h0, ch4, ar8});
        endcase
      end
      if ($urandom_range(0, 3) != 0) put(16'hF000);
      model_run();
      run_score(2000);
      check_run($sformatf("rand%0d", it));
      @(posedge clk); #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
